// File: rtl/bram_pim_arb_pkg.sv
// bram_pim_arb_pkg: arbiter state type and width helpers shared by the arbiter and its picker
package bram_pim_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int id_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/pim_rr_picker.sv
// pim_rr_picker: returns the first set request at or after start, wrapping around
module pim_rr_picker import bram_pim_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] gnt_id,
  output logic         any
);
  logic [W-1:0] k;
  always_comb begin
    gnt_id = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(start) + i) % N);
      if (req[k]) gnt_id = k;
    end
  end
  assign any = |req;
endmodule

// File: rtl/bram_pim_arbiter.sv
// bram_pim_arbiter: burst arbiter sharing one bram_pim port among NUM_REQ requesters.
// Define PIM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module bram_pim_arbiter import bram_pim_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data,
  input  logic [DATA_WIDTH-1:0]         mem_out,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);
  localparam int CNT_W = id_w(MAX_BURST);
  state_t                r_state;
  logic [ID_W-1:0]       r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_W-1:0]       w_gnt, w_start;
  logic                  w_any, w_burst, w_acc, w_rd, w_rel;
  // rst gates the grant so a beat presented in the reset cycle is neither written nor answered
  assign w_burst   = (r_state == BURST) && !rst;
  assign w_acc     = w_burst && req_valid[r_owner];
  assign w_rd      = w_acc && !req_we[r_owner];
  assign w_rel     = w_acc && (req_last[r_owner] || r_cnt == CNT_W'(MAX_BURST - 1));
  assign req_ready = w_burst ? NUM_REQ'(1) << r_owner : '0;
  assign mem_we    = w_acc && req_we[r_owner];
  assign mem_addr  = (r_state == BURST) ? req_addr[int'(r_owner) * ADDR_WIDTH +: ADDR_WIDTH] : r_addr;
  assign mem_data  = (r_state == BURST) ? req_data[int'(r_owner) * DATA_WIDTH +: DATA_WIDTH] : r_data;
  assign rsp_data  = mem_out;
`ifdef PIM_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_rel) r_ptr <= (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif
  pim_rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req(req_valid), .start(w_start), .gnt_id(w_gnt), .any(w_any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      r_addr    <= mem_addr;
      r_data    <= mem_data;
      rsp_valid <= w_rd;
      if (w_rd) rsp_id <= r_owner;
      if (r_state == IDLE && w_any) begin
        r_state <= BURST;
        r_owner <= w_gnt;
        r_cnt   <= '0;
      end else if (w_rel) r_state <= IDLE;
      else if (w_acc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bram_pim_arbiter.sv
// tb_bram_pim_arbiter: scoreboard bench for bram_pim_arbiter with a behavioural bram_pim model
module tb_bram_pim_arbiter;
  localparam int N = 4, AW = 11, DW = 8, MB = 4, IW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_we = '0, req_last = '0, req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic mem_we, rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_out, rsp_data;
  logic [IW-1:0] rsp_id;
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  logic [DW-1:0] shadow [2**AW] = '{default: '0};
  logic [IW+DW-1:0] sb [$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  bram_pim_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_last(req_last), .req_addr(req_addr), .req_data(req_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  // Scoreboard: reads push the shadow-model value on accept, responses pop and compare
  always @(negedge clk) begin
    logic [IW+DW-1:0] exp;
    if (pre_we) shadow[pre_addr] = pre_data;
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, want no response", rsp_id, rsp_data);
      end else begin
        exp = sb.pop_front();
        if ({rsp_id, rsp_data} !== exp) begin
          errors++;
          $display("FAIL rsp_data: got id=%0d data=%h, want id=%0d data=%h", rsp_id, rsp_data, exp[DW +: IW], exp[DW-1:0]);
        end
      end
    end
    for (int k = 0; k < N; k++)
      if (req_ready[k] === 1'b1 && req_valid[k] && !rst) begin
        if (req_we[k]) shadow[req_addr[k*AW +: AW]] = req_data[k*DW +: DW];
        else sb.push_back({IW'(k), shadow[req_addr[k*AW +: AW]]});
      end
  end

  task automatic drive(input int k, input bit v, input bit we, input bit last, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_we[k] = we;
    req_last[k] = last;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  // Drives an n-beat burst, advancing on accept; log[c] records req_ready[k] per cycle
  task automatic run_burst(input int k, input int n, input bit we, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input int bub_at, input string tag, output logic [15:0] log);
    int beat = 0, bub = 0;
    bit acc, v;
    log = '0;
    @(posedge clk); #1;
    drive(k, 1'b1, we, n == 1, a0, d0);
    for (int c = 0; c < 16 && beat < n; c++) begin
      @(negedge clk);
      log[c] = req_ready[k];
      acc = req_ready[k] && req_valid[k];
      if (acc) begin
        checks++;
        if (mem_we !== we || mem_addr !== a0 + AW'(beat) || (we && mem_data !== d0 + DW'(beat))) begin
          errors++;
          $display("FAIL %s beat%0d: mem_we=%b addr=%h data=%h, want we=%b addr=%h data=%h", tag, beat,
                   mem_we, mem_addr, mem_data, we, a0 + AW'(beat), d0 + DW'(beat));
        end
      end else if (!req_valid[k] && beat == bub_at) begin
        checks++;
        if (req_ready[k] !== 1'b1 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble: ready=%b mem_we=%b, want ready=1 mem_we=0", tag, req_ready[k], mem_we);
        end
      end
      @(posedge clk); #1;
      if (acc) beat++;
      if (beat < n) begin
        v = !(beat == bub_at && bub < 3);
        if (!v) bub++;
        drive(k, v, we, beat == n - 1, a0 + AW'(beat), d0 + DW'(beat));
      end
    end
    drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (beat < n) begin
      errors++;
      $display("FAIL %s timeout: accepted %0d beats, want %0d", tag, beat, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pre_we = 1'b1;
    pre_addr = AW'(5);
    pre_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    pre_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_we, rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b mem_we=%b rsp_valid=%b, want all 0", req_ready, mem_we, rsp_valid);
    end
    checks++;
    if (mem_addr !== '0 || mem_data !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h rsp_id=%0d, want 0", mem_addr, mem_data, rsp_id);
    end
  endtask

  task automatic test_single_read();
    logic [15:0] log;
    run_burst(2, 1, 1'b0, AW'(5), '0, -1, "single_read", log);
    checks++;
    if (log !== 16'h0002) begin
      errors++;
      $display("FAIL single_read_timing: ready log=%h, want 0002", log);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_read_rsp: valid=%b id=%0d data=%h, want 1 2 a5", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_forced_release();
    logic [15:0] log;
    run_burst(1, 6, 1'b1, AW'('h20), 8'h10, -1, "forced_wr", log);
    checks++;
    if (log !== 16'h00DE) begin
      errors++;
      $display("FAIL forced_release_timing: ready log=%h, want 00de", log);
    end
    run_burst(3, 4, 1'b0, AW'('h20), '0, -1, "forced_rd", log);
    checks++;
    if (log !== 16'h001E) begin
      errors++;
      $display("FAIL forced_readback_timing: ready log=%h, want 001e", log);
    end
  endtask

  task automatic test_bubble();
    logic [15:0] log;
    run_burst(2, 4, 1'b1, AW'('h40), 8'hB0, 2, "bubble_wr", log);
    checks++;
    if (log !== 16'h00FE) begin
      errors++;
      $display("FAIL bubble_timing: ready log=%h, want 00fe", log);
    end
    run_burst(0, 4, 1'b0, AW'('h40), '0, -1, "bubble_rd", log);
    checks++;
    if (log !== 16'h001E) begin
      errors++;
      $display("FAIL bubble_readback_timing: ready log=%h, want 001e", log);
    end
  endtask

  task automatic test_arbitration();
    int ids[5], cyc[5], got = 0, exp_id;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 1'b0, 1'b1, AW'(k), '0);
    for (int c = 0; c < 24 && got < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready)) begin
          errors++;
          $display("FAIL arb_onehot: ready=%b, want one-hot", req_ready);
        end
        for (int k = 0; k < N; k++) if (req_ready[k]) ids[got] = k;
        cyc[got] = c;
        got++;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL arb_timeout: saw %0d grants, want 5", got);
    end
    for (int i = 0; i < got; i++) begin
`ifdef PIM_ARB_ROUND_ROBIN_EN
      exp_id = i % N;
`else
      exp_id = 0;
`endif
      checks++;
      if (ids[i] != exp_id) begin
        errors++;
        $display("FAIL arb_order grant%0d: id=%0d, want %0d", i, ids[i], exp_id);
      end
      if (i > 0) begin
        checks++;
        if (cyc[i] - cyc[i-1] != 2) begin
          errors++;
          $display("FAIL arb_gap grant%0d: spacing=%0d cycles, want 2", i, cyc[i] - cyc[i-1]);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] log;
    run_burst(3, 1, 1'b0, AW'(5), '0, -1, "pre_reset_read", log);
    checks++;
    if (log !== 16'h0002) begin
      errors++;
      $display("FAIL pre_reset_read_timing: ready log=%h, want 0002", log);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset_rsp: valid=%b id=%0d data=%h, want 1 3 a5", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b0, 1'b1, AW'(5), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle: ready=%b mem_we=%b, want 0 0", req_ready, mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || req_ready !== '0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: rsp_valid=%b id=%0d ready=%b mem_we=%b, want all 0", rsp_valid, rsp_id, req_ready, mem_we);
    end
    checks++;
    if (mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_read_mem: addr=%h data=%h, want 0 0", mem_addr, mem_data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_forced_release();
    test_bubble();
    test_arbitration();
    test_reset_mid_read();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing: %0d reads unanswered, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
